fir_eq_engine: RTL and testbench
================================

// Module: fir_eq_engine
// PURPOSE
//  Parametrised multi-band FIR equaliser core; successor to the 4-tap single-band MAC.
//  Keeps an NTAPS-deep sample window and NBANDS coefficient sets.
//  Runs one time-multiplexed multiply-accumulate per cycle, scales each band by its gain and sums the bands.
//  Sits between the audio sample interface (signal/signal_en) and the output DAC path.
// PARAMETERS
//  DATA_W     16  sample width, signed two's complement
//  COEF_W     16  coefficient width, signed
//  GAIN_W      8  per-band gain width, unsigned
//  NTAPS       4  taps per band (>=2)
//  NBANDS      2  number of EQ bands (>=1)
//  OUT_W      34  result_o width
//  OUT_SHIFT   0  arithmetic right shift applied to the final sum before narrowing
// PORTS
//  clk          in   1                  clock, all state on rising edge
//  reset        in   1                  async, active-low; clears all state
//  signal_en    in   1                  sample strobe, one sample per high cycle
//  signal       in   DATA_W             input sample
//  eqVal        in   NBANDS*GAIN_W      band gains; band b at [b*GAIN_W +: GAIN_W]
//  coef_we      in   1                  coefficient write strobe
//  coef_band    in   clog2(NBANDS)      write band index
//  coef_tap     in   clog2(NTAPS)       write tap index
//  coef_wdata   in   COEF_W             write data
//  overrun_clr  in   1                  clears overrun
//  result_o     out  OUT_W              filtered sample, signed
//  done         out  1                  one-cycle pulse: result_o updated
//  busy         out  1                  high outside IDLE
//  overrun      out  1                  sticky: sample dropped while busy
// BEHAVIOUR
//  Reset: window, coef RAM, gain regs, acc, total, result_o, done, busy and overrun all 0; FSM enters IDLE.
//  Accept: in IDLE with signal_en=1 the window shifts (win[0]<=signal, win[i]<=win[i-1]).
//    eqVal is latched and band=tap=0; FSM goes to MAC.
//  MAC: one cycle per tap; acc += win[tap]*coef[band][tap] (full precision).
//    At tap=NTAPS-1 the FSM goes to GAIN.
//  GAIN: one cycle; total += acc*gain[band] (gain zero-extended); acc<=0.
//    If band<NBANDS-1: band++, tap<=0, back to MAC. Otherwise go to DONE.
//  DONE: result_o <= narrow(total>>>OUT_SHIFT); done=1 this cycle only; total<=0; next state IDLE.
//  Latency: done is high L = NBANDS*(NTAPS+1)+1 cycles after the accept edge (defaults: 11).
//    result_o holds until the next DONE.
//  Internal width: DATA_W+COEF_W+GAIN_W+clog2(NTAPS)+clog2(NBANDS)+1; no internal overflow.
//  signal_en while busy: sample dropped, window unchanged, overrun<=1.
//    overrun stays set until overrun_clr=1 or reset. Set and clear in the same cycle: set wins.
//  coef_we while busy: write ignored, so a frame uses coherent coefficients.
//  coef_we while IDLE: written at the clock edge.
//  coef_we and signal_en in the same IDLE cycle: both take effect; the new coefficient is used in this frame.
//  Out-of-range coef_band/coef_tap (non-power-of-2 sizes): write ignored.
//  Reset mid-frame: computation aborted, no done pulse; the frame is lost.
// CONFIGURATION
//  FIR_SAT_EN defined: narrowing saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  FIR_SAT_EN undefined: narrowing keeps the low OUT_W bits (wraps).
// TESTING (defaults unless stated; gains given as {band0,band1})
//  1 Band0 coefs [4,1,2,1], band1 zero, eqVal {1,0}; samples 1,2,3,4
//    -> result_o=24, done 11 cycles after the 4th accept.
//  2 As 1, band1 coefs [1,1,1,1], eqVal {2,3} -> result_o=78.
//  3 After reset, band0 tap0=0x7FFF, band1 zero, eqVal {255,0}; sample 0xFFFF
//    -> result_o=-8355585 (sign-extended).
//  4 OUT_W=16, NBANDS=1, tap0=0x7FFF, gain 1, sample 0x7FFF
//    -> result_o=0x7FFF with FIR_SAT_EN, 0x0001 without.
//  5 signal_en held 3 cycles -> one sample accepted, overrun=1; overrun_clr pulse -> overrun=0.
//  6 reset low 1 cycle during MAC -> no done pulse; result_o=0, busy=0, coefs read back 0.

Source files
------------

// File: rtl/fir_eq_engine.sv
// fir_eq_engine: multi-band FIR equaliser, one time-multiplexed MAC per cycle.
// Optional FIR_SAT_EN: saturate (instead of wrap) when narrowing to OUT_W.
module fir_eq_engine #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int GAIN_W    = 8,
    parameter int NTAPS     = 4,
    parameter int NBANDS    = 2,
    parameter int OUT_W     = 34,
    parameter int OUT_SHIFT = 0
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        signal_en,
    input  logic signed [DATA_W-1:0]                    signal,
    input  logic [NBANDS*GAIN_W-1:0]                    eqVal,
    input  logic                                        coef_we,
    input  logic [$clog2(NBANDS > 1 ? NBANDS : 2)-1:0]  coef_band,
    input  logic [$clog2(NTAPS)-1:0]                    coef_tap,
    input  logic signed [COEF_W-1:0]                    coef_wdata,
    input  logic                                        overrun_clr,
    output logic signed [OUT_W-1:0]                     result_o,
    output logic                                        done,
    output logic                                        busy,
    output logic                                        overrun
);

    localparam int BW = $clog2(NBANDS > 1 ? NBANDS : 2);
    localparam int TW = $clog2(NTAPS);
    localparam int IW = DATA_W + COEF_W + GAIN_W + TW + $clog2(NBANDS) + 1;
    localparam int XW = (IW > OUT_W) ? IW : OUT_W;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_GAIN, S_DONE} state_t;

    state_t                   state;
    logic signed [DATA_W-1:0] win  [NTAPS];
    logic signed [COEF_W-1:0] coef [NBANDS][NTAPS];
    logic [GAIN_W-1:0]        gain [NBANDS];
    logic [BW-1:0]            band;
    logic [TW-1:0]            tap;
    logic signed [IW-1:0]     acc;
    logic signed [IW-1:0]     total;

    logic signed [DATA_W-1:0] cur_win;
    logic signed [COEF_W-1:0] cur_coef;
    logic [GAIN_W-1:0]        cur_gain;
    logic signed [IW-1:0]     mac_term;
    logic signed [IW-1:0]     gain_term;
    logic signed [XW-1:0]     shifted;
    logic signed [OUT_W-1:0]  narrowed;

    always_comb begin
        cur_win  = '0;
        cur_coef = '0;
        cur_gain = '0;
        for (int t = 0; t < NTAPS; t++)
            if (tap == TW'(t)) cur_win = win[t];
        for (int b = 0; b < NBANDS; b++) begin
            if (band == BW'(b)) begin
                cur_gain = gain[b];
                for (int t = 0; t < NTAPS; t++)
                    if (tap == TW'(t)) cur_coef = coef[b][t];
            end
        end
    end

    assign mac_term  = IW'(cur_win) * IW'(cur_coef);
    // gains are unsigned: zero-extend before the signed multiply
    assign gain_term = acc * IW'($signed({1'b0, cur_gain}));
    assign shifted   = XW'(total) >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
    logic [XW-OUT_W:0] hi;
    assign hi = shifted[XW-1:OUT_W-1];

    always_comb begin
        narrowed = OUT_W'(shifted);
        if (!((&hi) || !(|hi)))
            narrowed = hi[XW-OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
    end
`else
    assign narrowed = OUT_W'(shifted);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            band     <= '0;
            tap      <= '0;
            acc      <= '0;
            total    <= '0;
            result_o <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            for (int i = 0; i < NTAPS; i++) win[i] <= '0;
            for (int b = 0; b < NBANDS; b++) begin
                gain[b] <= '0;
                for (int t = 0; t < NTAPS; t++) coef[b][t] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (signal_en && state != S_IDLE)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;

            // frozen while a frame runs so every frame sees one coefficient set
            if (coef_we && state == S_IDLE)
                for (int b = 0; b < NBANDS; b++)
                    for (int t = 0; t < NTAPS; t++)
                        if (coef_band == BW'(b) && coef_tap == TW'(t))
                            coef[b][t] <= coef_wdata;

            unique case (state)
                S_IDLE: begin
                    if (signal_en) begin
                        win[0] <= signal;
                        for (int i = 1; i < NTAPS; i++) win[i] <= win[i-1];
                        for (int b = 0; b < NBANDS; b++)
                            gain[b] <= eqVal[b*GAIN_W +: GAIN_W];
                        band  <= '0;
                        tap   <= '0;
                        state <= S_MAC;
                        busy  <= 1'b1;
                    end
                end
                S_MAC: begin
                    acc <= acc + mac_term;
                    if (tap == TW'(NTAPS-1))
                        state <= S_GAIN;
                    else
                        tap <= tap + 1'b1;
                end
                S_GAIN: begin
                    total <= total + gain_term;
                    acc   <= '0;
                    if (band == BW'(NBANDS-1)) begin
                        state <= S_DONE;
                    end else begin
                        band  <= band + 1'b1;
                        tap   <= '0;
                        state <= S_MAC;
                    end
                end
                S_DONE: begin
                    result_o <= narrowed;
                    done     <= 1'b1;
                    total    <= '0;
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_eq_engine.sv
// tb_fir_eq_engine: directed vectors, arithmetic reference model, per-cycle compare.
// Also covers a narrow single-band instance (OUT_W=16, NBANDS=1).
module tb_fir_eq_engine;

    localparam int  OW   = 34;
    localparam int  LAT  = 11;
    localparam longint OMAX = (longint'(1) <<< (OW-1)) - 1;
    localparam longint OMIN = -(longint'(1) <<< (OW-1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               signal_en = 1'b0;
    logic signed [15:0] signal = '0;
    logic [15:0]        eqVal = '0;
    logic               coef_we = 1'b0;
    logic [0:0]         coef_band = '0;
    logic [1:0]         coef_tap = '0;
    logic signed [15:0] coef_wdata = '0;
    logic               overrun_clr = 1'b0;
    logic signed [OW-1:0] result_o;
    logic               done, busy, overrun;

    fir_eq_engine u_dut (
        .clk(clk), .reset(rst_n), .signal_en(signal_en), .signal(signal),
        .eqVal(eqVal), .coef_we(coef_we), .coef_band(coef_band),
        .coef_tap(coef_tap), .coef_wdata(coef_wdata),
        .overrun_clr(overrun_clr), .result_o(result_o), .done(done),
        .busy(busy), .overrun(overrun)
    );

    logic               s_en = 1'b0;
    logic signed [15:0] s_sig = '0;
    logic [7:0]         s_eq = '0;
    logic               s_we = 1'b0;
    logic [0:0]         s_band = '0;
    logic [1:0]         s_tap = '0;
    logic signed [15:0] s_wd = '0;
    logic               s_clr = 1'b0;
    logic signed [15:0] s_res;
    logic               s_done, s_busy, s_over;

    fir_eq_engine #(.OUT_W(16), .NBANDS(1)) u_narrow (
        .clk(clk), .reset(rst_n), .signal_en(s_en), .signal(s_sig),
        .eqVal(s_eq), .coef_we(s_we), .coef_band(s_band),
        .coef_tap(s_tap), .coef_wdata(s_wd), .overrun_clr(s_clr),
        .result_o(s_res), .done(s_done), .busy(s_busy), .overrun(s_over)
    );

    int n_run = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint mwin [4];
    longint mcoef [2][4];
    bit     m_idle = 1'b1;
    bit     m_done = 1'b0;
    bit     m_over = 1'b0;
    longint m_result = 0;
    longint m_exp = 0;
    int     cyc = 0;
    int     m_due = 0;

    function automatic longint coef_eff(input int b, input int t);
        if (coef_we && m_idle && b == int'(coef_band) && t == int'(coef_tap))
            return longint'(coef_wdata);
        return mcoef[b][t];
    endfunction

    function automatic longint win_eff(input int i);
        return (i == 0) ? longint'(signal) : mwin[i-1];
    endfunction

    function automatic longint frame_now();
        longint s = 0;
        for (int b = 0; b < 2; b++) begin
            longint bs = 0;
            for (int t = 0; t < 4; t++) bs += win_eff(t) * coef_eff(b, t);
            s += bs * longint'(eqVal[b*8 +: 8]);
        end
        return s;
    endfunction

    function automatic longint narrow(input longint v);
`ifdef FIR_SAT_EN
        if (v > OMAX) return OMAX;
        if (v < OMIN) return OMIN;
        return v;
`else
        return (v <<< (64-OW)) >>> (64-OW);
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc      <= 0;
            m_idle   <= 1'b1;
            m_done   <= 1'b0;
            m_over   <= 1'b0;
            m_result <= 0;
            for (int i = 0; i < 4; i++) mwin[i] <= 0;
            for (int b = 0; b < 2; b++)
                for (int t = 0; t < 4; t++) mcoef[b][t] <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_idle && coef_we)
                mcoef[int'(coef_band)][int'(coef_tap)] <= longint'(coef_wdata);
            if (m_idle && signal_en) begin
                m_exp  <= narrow(frame_now());
                m_due  <= cyc + LAT;
                m_idle <= 1'b0;
                for (int i = 0; i < 4; i++) mwin[i] <= win_eff(i);
            end
            if (!m_idle && signal_en)
                m_over <= 1'b1;
            else if (overrun_clr)
                m_over <= 1'b0;
            if (!m_idle && cyc == m_due) begin
                m_done   <= 1'b1;
                m_result <= m_exp;
                m_idle   <= 1'b1;
            end else begin
                m_done <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("done", longint'(done), longint'(m_done));
            check("busy", longint'(busy), longint'(!m_idle));
            check("overrun", longint'(overrun), longint'(m_over));
            check("result_o", longint'(result_o), m_result);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wcoef(input int b, input int t, input int v);
        coef_band  = 1'(b);
        coef_tap   = 2'(t);
        coef_wdata = 16'(v);
        coef_we    = 1'b1;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic send(input int s);
        signal    = 16'(s);
        signal_en = 1'b1;
        tick();
        signal_en = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            n_run++;
            n_fail++;
            $display("FAIL wait_done: no done within %0d cycles", n);
        end
    endtask

    int     n;
    bit     saw;
    longint big;

    initial begin
        repeat (2) tick();
        check("reset result_o", longint'(result_o), 0);
        check("reset busy", longint'(busy), 0);
        check("reset done", longint'(done), 0);
        check("reset overrun", longint'(overrun), 0);
        rst_n = 1'b1;
        tick();

        // band0 [4,1,2,1], gains {1,0}, samples 1..4
        wcoef(0, 0, 4); wcoef(0, 1, 1); wcoef(0, 2, 2); wcoef(0, 3, 1);
        eqVal = {8'd0, 8'd1};
        for (int s = 1; s <= 4; s++) begin
            send(s);
            wait_done(n);
        end
        check("t1 latency", n, 11);
        check("t1 result", longint'(result_o), 24);

        // band1 [1,1,1,1], gains {2,3}
        for (int t = 0; t < 4; t++) wcoef(1, t, 1);
        eqVal = {8'd3, 8'd2};
        for (int s = 1; s <= 4; s++) begin
            send(s);
            wait_done(n);
        end
        check("t2 result", longint'(result_o), 78);

        // write during a frame is ignored
        send(5);
        tick();
        wcoef(0, 0, 100);
        wait_done(n);
        check("busy write ignored", longint'(result_o), 106);

        // write and accept together: new coefficient used
        coef_band  = 1'b0;
        coef_tap   = 2'd0;
        coef_wdata = 16'sd10;
        coef_we    = 1'b1;
        send(6);
        coef_we = 1'b0;
        wait_done(n);
        check("write+accept", longint'(result_o), 206);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        wcoef(0, 0, 16'h7FFF);
        eqVal = {8'd0, 8'd255};
        send(16'hFFFF);
        wait_done(n);
        check("t3 negative", longint'(result_o), -8355585);

        // narrowing at OUT_W=34
        for (int b = 0; b < 2; b++)
            for (int t = 0; t < 4; t++) wcoef(b, t, 16'h8000);
        eqVal = {8'd255, 8'd255};
        for (int i = 0; i < 4; i++) begin
            send(16'h8000);
            wait_done(n);
        end
`ifdef FIR_SAT_EN
        big = OMAX;
`else
        big = OMIN;
`endif
        check("narrowing", longint'(result_o), big);

        // overrun
        signal    = 16'sd7;
        signal_en = 1'b1;
        repeat (3) tick();
        signal_en = 1'b0;
        check("overrun set", longint'(overrun), 1);
        signal_en   = 1'b1;
        overrun_clr = 1'b1;
        tick();
        signal_en   = 1'b0;
        overrun_clr = 1'b0;
        check("set beats clr", longint'(overrun), 1);
        wait_done(n);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("overrun clr", longint'(overrun), 0);

        // reset mid-MAC
        send(1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            tick();
            if (done) saw = 1'b1;
        end
        check("abort no done", longint'(saw), 0);
        check("abort result", longint'(result_o), 0);
        check("abort busy", longint'(busy), 0);
        eqVal = {8'd255, 8'd255};
        send(16'h1234);
        wait_done(n);
        check("coefs cleared", longint'(result_o), 0);

        // narrow single-band instance
        s_tap = 2'd0;
        s_wd  = 16'h7FFF;
        s_we  = 1'b1;
        tick();
        s_we  = 1'b0;
        s_eq  = 8'd1;
        s_sig = 16'h7FFF;
        s_en  = 1'b1;
        tick();
        s_en = 1'b0;
        n = 0;
        while (!s_done && n < 40) begin
            tick();
            n++;
        end
        check("t4 latency", n, 6);
`ifdef FIR_SAT_EN
        check("t4 result", longint'(s_res), 32767);
`else
        check("t4 result", longint'(s_res), 1);
`endif

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
